// File: rtl/approx_add_sched_if.sv
// Handshake bundle between two requesters, one response consumer and approx_add_sched.
// The master side drives requests and consumes responses; the slave side is the scheduler.
interface approx_add_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_sub;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_sub;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/approx_add_sched.sv
// Round-robin scheduler that runs 32-bit add/sub for two requesters on one shared
// 16-bit approximate adder, low half first and high half with the registered carry.
module x16_approx_add #(
  parameter int N8 = 0
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  generate
    if (N8 == 0) begin : g_exact
      logic [16:0] full;
      assign full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      assign sum  = full[15:0];
      assign cout = full[16];
    end else begin : g_approx
      localparam int K = (N8 > 15) ? 15 : N8;
      logic [16-K:0] upper;
      logic [K-1:0]  lower;
      // Lower-part OR cells; the top approximate bit pair seeds the exact upper carry.
      assign lower = a[K-1:0] | b[K-1:0] | K'(cin);
      assign upper = {1'b0, a[15:K]} + {1'b0, b[15:K]} + {{(16-K){1'b0}}, a[K-1] & b[K-1]};
      assign sum   = {upper[15-K:0], lower};
      assign cout  = upper[16-K];
    end
  endgenerate
endmodule

module approx_add_sched #(
  parameter int N8 = 0
) (
  input  logic               clk,
  input  logic               resetn,
  approx_add_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic        last;
  logic        op_id;
  logic        cin0;
  logic        carry;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [15:0] sum_lo;

  logic        rsp_valid;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_id;

  logic        grant_any;
  logic        grant_id;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  // On a tie the requester that did not win last time is granted.
  assign grant_any = resetn && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign grant_id  = bus.req1_valid && (!bus.req0_valid || !last);

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any && grant_id;

  assign sel_a   = grant_id ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant_id ? bus.req1_b   : bus.req0_b;
  assign sel_sub = grant_id ? bus.req1_sub : bus.req0_sub;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_cout  = rsp_cout;
  assign bus.rsp_id    = rsp_id;

  always_comb begin
    add_a   = 16'd0;
    add_b   = 16'd0;
    add_cin = 1'b0;
    case (state)
      LO: begin
        add_a   = op_a[15:0];
        add_b   = op_b[15:0];
        add_cin = cin0;
      end
      HI: begin
        add_a   = op_a[31:16];
        add_b   = op_b[31:16];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  x16_approx_add #(.N8(N8)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      last      <= 1'b1;
      op_id     <= 1'b0;
      cin0      <= 1'b0;
      carry     <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      sum_lo    <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_sum   <= 32'd0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_id <= grant_id;
            last  <= grant_id;
            op_a  <= sel_a;
            // Subtraction is a + ~b + 1, so the low beat carries in the sub flag.
            op_b  <= sel_sub ? ~sel_b : sel_b;
            cin0  <= sel_sub;
            state <= LO;
          end
        end
        LO: begin
          sum_lo <= add_sum;
          carry  <= add_cout;
          state  <= HI;
        end
        HI: begin
          rsp_sum   <= {add_sum, sum_lo};
          rsp_cout  <= add_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_approx_add_sched.sv
// Bench for approx_add_sched: directed vector table plus a scoreboard fed from observed
// request handshakes and drained on response handshakes.
module tb_approx_add_sched;
  typedef struct {
    logic        id;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        id;
  } exp_t;

  logic clk;
  logic resetn;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t sb_q[$];
  logic rsp_id_log[$];
  int   grant_cyc_log[$];

  vec_t vecs[9];

  approx_add_sched_if bus ();

  approx_add_sched #(.N8(0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic id);
    exp_t e;
    logic [32:0] r;
    if (sub) begin
      r[31:0] = a - b;
      r[32]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    e.sum  = r[31:0];
    e.cout = r[32];
    e.id   = id;
    return e;
  endfunction

  // Scoreboard: push on request handshakes, pop and compare on response handshakes.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.req0_ready || bus.req1_ready) begin
        check_output("ready_onehot", {31'd0, bus.req0_ready && bus.req1_ready}, 32'd0);
        if (bus.req0_ready && bus.req0_valid) begin
          sb_q.push_back(model(bus.req0_a, bus.req0_b, bus.req0_sub, 1'b0));
          grant_cyc_log.push_back(cyc);
        end else if (bus.req1_ready && bus.req1_valid) begin
          sb_q.push_back(model(bus.req1_a, bus.req1_b, bus.req1_sub, 1'b1));
          grant_cyc_log.push_back(cyc);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_output("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_output("sb_sum", bus.rsp_sum, e.sum);
          check_output("sb_cout", {31'd0, bus.rsp_cout}, {31'd0, e.cout});
          check_output("sb_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        end
        rsp_id_log.push_back(bus.rsp_id);
      end
    end
  end

  task automatic drive_req(input logic id, input logic valid, input logic [31:0] a,
                           input logic [31:0] b, input logic sub);
    if (id) begin
      bus.req1_valid = valid;
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_sub   = sub;
    end else begin
      bus.req0_valid = valid;
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_sub   = sub;
    end
  endtask

  task automatic wait_grant(input logic id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    check_output(name, {31'd0, done}, 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bit ok;
    int cycles;
    @(posedge clk);
    #1;
    drive_req(v.id, 1'b1, v.a, v.b, v.sub);
    wait_grant(v.id, ok);
    @(posedge clk);
    #1;
    drive_req(v.id, 1'b0, $urandom, $urandom, ~v.sub);
    if (ok) begin
      wait_rsp(cycles);
      check_output("latency", 32'(cycles), 32'd3);
      check_output("vec_sum", bus.rsp_sum, v.exp_sum);
      check_output("vec_cout", {31'd0, bus.rsp_cout}, {31'd0, v.exp_cout});
      check_output("vec_id", {31'd0, bus.rsp_id}, {31'd0, v.id});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check_output({tag, "_rsp_sum"}, bus.rsp_sum, 32'd0);
    check_output({tag, "_rsp_cout"}, {31'd0, bus.rsp_cout}, 32'd0);
    check_output({tag, "_rsp_id"}, {31'd0, bus.rsp_id}, 32'd0);
    check_output({tag, "_ready0"}, {31'd0, bus.req0_ready}, 32'd0);
    check_output({tag, "_ready1"}, {31'd0, bus.req1_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ok;
    int cycles;

    vecs[0] = '{1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1};

    // Reset with both requesters already valid; nothing may be granted yet.
    resetn        = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    drive_req(1'b1, 1'b1, 32'd1, 32'd0, 1'b0);
    #12;
    check_reset_outputs("reset");

    // Fairness: both valid continuously from reset release.
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 40 && rsp_id_log.size() < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    check_output("fair_rsp_count", 32'(rsp_id_log.size()), 32'd4);
    if (rsp_id_log.size() >= 4 && grant_cyc_log.size() >= 4) begin
      for (int k = 0; k < 4; k++)
        check_output($sformatf("fair_id%0d", k), {31'd0, rsp_id_log[k]}, 32'(k % 2));
      for (int k = 1; k < 4; k++)
        check_output($sformatf("fair_gap%0d", k),
                     32'(grant_cyc_log[k] - grant_cyc_log[k-1]), 32'd4);
    end
    wait_drain("fair_drain");

    // Directed vector table.
    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);
    wait_drain("table_drain");

    // Backpressure: response must hold and no grant may happen while pending.
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
    wait_grant(1'b0, ok);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_req(1'b1, 1'b1, 32'd5, 32'd3, 1'b0);
    wait_rsp(cycles);
    check_output("bp_latency", 32'(cycles), 32'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check_output("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check_output("bp_sum", bus.rsp_sum, 32'h33333333);
      check_output("bp_cout", {31'd0, bus.rsp_cout}, 32'd0);
      check_output("bp_id", {31'd0, bus.rsp_id}, 32'd0);
      check_output("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check_output("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(negedge clk);
    check_output("bp_next_grant", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_drain("bp_drain");

    // Reset during HI: in-flight op discarded, last returns to 1.
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b1, 32'h00000001, 32'h00000002, 1'b0);
    wait_grant(1'b0, ok);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("midreset");
    drive_req(1'b0, 1'b1, 32'h00000100, 32'h00000023, 1'b0);
    drive_req(1'b1, 1'b1, 32'h00000007, 32'h00000007, 1'b1);
    #1;
    check_output("midreset_hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check_output("midreset_hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(negedge clk);
    check_output("midreset_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check_output("midreset_no_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_output("post_reset_grant0", {31'd0, bus.req0_ready}, 32'd1);
    check_output("post_reset_grant1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
